demux1x2_hs: RTL and testbench
==============================

Name: demux1x2_hs

Overview:
- Registered 1-to-2 demultiplexer with valid/ready handshakes; the steering counterpart to the PE's 2:1 selection mux.
- Accepts one data word plus a select bit per transfer and routes it into one of two per-output FIFOs. Each output drains independently.
- Typical use is psum steering inside the PE: output 0 goes back to the psum scratchpad, output 1 goes to the next PE's psum_in.
- A stall on one output never blocks transfers destined for the other output.

Parameters:
- DATA_WIDTH, 16, width of in_data / out0_data / out1_data.
- FIFO_DEPTH, 2, entries per output FIFO; power of two, >= 2.
- CNT_WIDTH, 16, width of per-output transfer counters (used only when DEMUX_COUNT_EN is defined).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  DATA_WIDTH  word to be routed
- in_sel  input  1  0 -> output 0, 1 -> output 1; qualified by in_valid
- in_valid  input  1  producer has a word
- in_ready  output  1  demux can accept the word for the currently selected output
- out0_data  output  DATA_WIDTH  head of FIFO 0
- out0_valid  output  1  FIFO 0 not empty
- out0_ready  input  1  consumer 0 accepts
- out1_data  output  DATA_WIDTH  head of FIFO 1
- out1_valid  output  1  FIFO 1 not empty
- out1_ready  input  1  consumer 1 accepts
- out0_count  output  CNT_WIDTH  words popped from output 0 (DEMUX_COUNT_EN only)
- out1_count  output  CNT_WIDTH  words popped from output 1 (DEMUX_COUNT_EN only)

Behaviour:
- Reset (rst_n low, asynchronous):
  - Both FIFOs empty; out0_valid = out1_valid = 0.
  - outN_data = 0; counters = 0.
  - in_ready reflects the empty FIFOs (1) once reset releases.
- in_ready is combinational: in_sel ? !full1 : !full0. No pass-through when full: a pop in the same cycle does not free the slot for a push that cycle.
- Push: in_valid && in_ready at a rising edge writes in_data into FIFO[in_sel].
- Pop: outN_valid && outN_ready at a rising edge removes the head of FIFO N.
- Latency: a word pushed at edge k is visible on outN_data with outN_valid = 1 after edge k (one cycle). There is no combinational in -> out path.
- outN_data equals the FIFO head whenever outN_valid = 1. It holds its last value when the FIFO is empty; it is 0 after reset.
- Simultaneous push and pop on the same FIFO when not full: both occur and occupancy is unchanged. When empty, only the push occurs.
- Simultaneous pop on FIFO 0 and FIFO 1 plus a push to either: all legal, independent.
- Ordering: per-output FIFO order is preserved. There is no ordering relation between outputs.
- Pointers: per FIFO, write and read pointers of log2(FIFO_DEPTH)+1 bits.
  - full = MSBs differ and low bits equal.
  - empty = pointers equal.
  - Wrap-around is natural.
- Producer rules: in_data and in_sel must stay stable while in_valid = 1 and in_ready = 0. A change of in_sel under stall is a protocol violation (assertion in the bench).
- Reset mid-operation clears all contents immediately. Words in flight are discarded.

Optional Feature:
- Macro: DEMUX_COUNT_EN.
- Defined:
  - out0_count and out1_count each increment by 1 on every pop of their output.
  - They wrap modulo 2^CNT_WIDTH.
  - They reset to 0.
- Undefined:
  - Counter logic is removed.
  - The count ports still exist and are tied to 0.
  - Handshake behaviour is identical.

Decomposition:
- pe_pkg holds:
  - default DATA_WIDTH = 16
  - SEL_OUT0 = 1'b0, SEL_OUT1 = 1'b1
  - a function computing log2 of FIFO_DEPTH for pointer widths
- One sub-module, demux_fifo: synchronous FIFO parameterised by DATA_WIDTH/FIFO_DEPTH, with push, pop, full, empty and head data. It is instantiated twice.
- The top level holds the select/ready logic and the optional counters.

Test Plan:
- Reset, then in_valid = 1, in_sel = 0, in_data = 0x00A5 for one cycle, outputs ready -> next cycle out0_valid = 1 with out0_data = 0x00A5; out1_valid stays 0.
- out1_ready = 0; push 0x0001, 0x0002 with sel = 1 -> after 2 pushes, in_ready = 0 while in_sel = 1. Switch to sel = 0 and push 0x0003 -> accepted (in_ready = 1); out0 shows 0x0003.
- FIFO 1 full; in the same cycle assert out1_ready = 1 and push 0x0004 with sel = 1 -> pop of 0x0001 occurs, push is refused; next cycle in_ready = 1 and out1_data = 0x0002.
- Stream 10 words alternating sel with random outN_ready -> each output receives its words in order (0,2,4,6,8 / 1,3,5,7,9) with no loss or duplication.
- Assert rst_n low while both FIFOs hold data -> out0_valid/out1_valid drop to 0 immediately (asynchronously); after release, in_ready = 1 and the FIFOs are empty.
- With DEMUX_COUNT_EN and CNT_WIDTH = 4: pop 17 words from out0 -> out0_count = 1 (wrap); out1_count = 0.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared constants and helpers for the PE steering blocks (demux1x2_hs and its FIFO).
package pe_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 16;

   localparam logic SEL_OUT0 = 1'b0;
   localparam logic SEL_OUT1 = 1'b1;

   // Ceiling log2; FIFO depths are powers of two so this is exact in practice.
   function automatic int unsigned depth_log2(input int unsigned depth);
      int unsigned v;
      int unsigned n;
      v = 1;
      n = 0;
      while (v < depth) begin
         v = v << 1;
         n = n + 1;
      end
      return n;
   endfunction

endpackage

// File: rtl/demux_fifo.sv
// Synchronous FIFO with a registered head word: head holds its last value when empty
// and is 0 after reset. Pointers carry one extra wrap bit to distinguish full from empty.
module demux_fifo
   import pe_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_pop,
   output logic                  o_full,
   output logic                  o_empty,
   output logic [DATA_WIDTH-1:0] o_data
);

   localparam int unsigned AW = depth_log2(FIFO_DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [PW-1:0]         r_wptr;
   logic [PW-1:0]         r_rptr;
   logic [DATA_WIDTH-1:0] r_head;

   logic          w_push_ok;
   logic          w_pop_ok;
   logic [PW-1:0] w_wptr_nxt;
   logic [PW-1:0] w_rptr_nxt;

   assign o_empty = (r_wptr == r_rptr);
   assign o_full  = (r_wptr[PW-1] != r_rptr[PW-1]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

   // Full blocks a push even if a pop happens in the same cycle.
   assign w_push_ok = i_push && !o_full;
   assign w_pop_ok  = i_pop && !o_empty;

   assign w_wptr_nxt = w_push_ok ? r_wptr + PW'(1) : r_wptr;
   assign w_rptr_nxt = w_pop_ok  ? r_rptr + PW'(1) : r_rptr;

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wptr[AW-1:0]] <= i_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_head <= '0;
      end else begin
         r_wptr <= w_wptr_nxt;
         r_rptr <= w_rptr_nxt;
         // The next head is the word being written this edge when it lands in the head slot.
         if (w_wptr_nxt != w_rptr_nxt) begin
            if (w_push_ok && (w_rptr_nxt == r_wptr)) begin
               r_head <= i_data;
            end else begin
               r_head <= r_mem[w_rptr_nxt[AW-1:0]];
            end
         end
      end
   end

   assign o_data = r_head;

endmodule

// File: rtl/demux1x2_hs.sv
// Registered 1-to-2 valid/ready demultiplexer with one FIFO per output.
// Optional per-output pop counters are enabled by defining DEMUX_COUNT_EN.
module demux1x2_hs
   import pe_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_sel,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out0_data,
   output logic                  out0_valid,
   input  logic                  out0_ready,
   output logic [DATA_WIDTH-1:0] out1_data,
   output logic                  out1_valid,
   input  logic                  out1_ready,
   output logic [CNT_WIDTH-1:0]  out0_count,
   output logic [CNT_WIDTH-1:0]  out1_count
);

   logic w_full0;
   logic w_full1;
   logic w_empty0;
   logic w_empty1;
   logic w_push0;
   logic w_push1;
   logic w_pop0;
   logic w_pop1;

   assign in_ready = (in_sel == SEL_OUT1) ? !w_full1 : !w_full0;

   assign w_push0 = in_valid && in_ready && (in_sel == SEL_OUT0);
   assign w_push1 = in_valid && in_ready && (in_sel == SEL_OUT1);

   assign out0_valid = !w_empty0;
   assign out1_valid = !w_empty1;

   assign w_pop0 = out0_valid && out0_ready;
   assign w_pop1 = out1_valid && out1_ready;

   demux_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push0),
      .i_data  (in_data),
      .i_pop   (w_pop0),
      .o_full  (w_full0),
      .o_empty (w_empty0),
      .o_data  (out0_data)
   );

   demux_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push1),
      .i_data  (in_data),
      .i_pop   (w_pop1),
      .o_full  (w_full1),
      .o_empty (w_empty1),
      .o_data  (out1_data)
   );

`ifdef DEMUX_COUNT_EN
   logic [CNT_WIDTH-1:0] r_cnt0;
   logic [CNT_WIDTH-1:0] r_cnt1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else begin
         if (w_pop0) r_cnt0 <= r_cnt0 + CNT_WIDTH'(1);
         if (w_pop1) r_cnt1 <= r_cnt1 + CNT_WIDTH'(1);
      end
   end

   assign out0_count = r_cnt0;
   assign out1_count = r_cnt1;
`else
   assign out0_count = '0;
   assign out1_count = '0;
`endif

endmodule

// File: tb/tb_demux1x2_hs.sv
// Directed self-checking bench for demux1x2_hs (count checks adapt to DEMUX_COUNT_EN).
module tb_demux1x2_hs;

   localparam int DW = 16;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] in_data;
   logic          in_sel;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] out0_data;
   logic          out0_valid;
   logic          out0_ready;
   logic [DW-1:0] out1_data;
   logic          out1_valid;
   logic          out1_ready;
   logic [CW-1:0] out0_count;
   logic [CW-1:0] out1_count;

   int n_assert = 0;
   int n_fail   = 0;

   demux1x2_hs #(.DATA_WIDTH(DW), .FIFO_DEPTH(2), .CNT_WIDTH(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out0_data  (out0_data),
      .out0_valid (out0_valid),
      .out0_ready (out0_ready),
      .out1_data  (out1_data),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .out0_count (out0_count),
      .out1_count (out1_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Producer must hold in_sel/in_data while stalled.
   logic          p_stall = 1'b0;
   logic          p_sel;
   logic [DW-1:0] p_data;
   always @(posedge clk) begin
      if (rst_n === 1'b1 && p_stall && in_valid) begin
         chk("proto_sel_stable", {31'd0, in_sel}, {31'd0, p_sel});
         chk("proto_data_stable", {16'd0, in_data}, {16'd0, p_data});
      end
      p_stall = (rst_n === 1'b1) && in_valid && !in_ready;
      p_sel   = in_sel;
      p_data  = in_data;
   end

   initial begin
      int idx;
      int got0;
      int got1;
      int cyc;

      rst_n      = 1'b0;
      in_data    = '0;
      in_sel     = 1'b0;
      in_valid   = 1'b0;
      out0_ready = 1'b1;
      out1_ready = 1'b1;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      chk("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
      chk("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
      chk("rst_out0_data", {16'd0, out0_data}, 32'd0);
      chk("rst_out1_data", {16'd0, out1_data}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_count0", {28'd0, out0_count}, 32'd0);
      chk("rst_count1", {28'd0, out1_count}, 32'd0);

      // Single word to output 0
      in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h00A5;
      tick();
      in_valid = 1'b0;
      chk("t1_out0_valid", {31'd0, out0_valid}, 32'd1);
      chk("t1_out0_data", {16'd0, out0_data}, 32'h00A5);
      chk("t1_out1_valid", {31'd0, out1_valid}, 32'd0);
      tick();
      chk("t1_out0_drained", {31'd0, out0_valid}, 32'd0);
      chk("t1_out0_hold", {16'd0, out0_data}, 32'h00A5);

      // Fill FIFO 1, output 0 still accepts
      out0_ready = 1'b0; out1_ready = 1'b0;
      in_valid = 1'b1; in_sel = 1'b1; in_data = 16'h0001;
      tick();
      in_data = 16'h0002;
      tick();
      #1;
      chk("t2_full1_in_ready", {31'd0, in_ready}, 32'd0);
      chk("t2_out1_valid", {31'd0, out1_valid}, 32'd1);
      chk("t2_out1_head", {16'd0, out1_data}, 32'h0001);
      in_valid = 1'b0;
      in_sel = 1'b0; in_data = 16'h0003; in_valid = 1'b1;
      #1;
      chk("t2_sel0_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      chk("t2_out0_valid", {31'd0, out0_valid}, 32'd1);
      chk("t2_out0_data", {16'd0, out0_data}, 32'h0003);

      // Full FIFO 1: pop and refused push in the same cycle
      in_sel = 1'b1; in_data = 16'h0004; in_valid = 1'b1; out1_ready = 1'b1;
      #1;
      chk("t3_refuse_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("t3_after_pop_in_ready", {31'd0, in_ready}, 32'd1);
      chk("t3_out1_data", {16'd0, out1_data}, 32'h0002);
      chk("t3_out1_valid", {31'd0, out1_valid}, 32'd1);
      tick();
      in_valid = 1'b0;
      chk("t3_out1_data4", {16'd0, out1_data}, 32'h0004);
      tick();
      chk("t3_out1_empty", {31'd0, out1_valid}, 32'd0);
      chk("t3_out0_still", {16'd0, out0_data}, 32'h0003);
      out0_ready = 1'b1;
      tick();
      chk("t3_out0_empty", {31'd0, out0_valid}, 32'd0);

      // Stream 10 alternating words with random back-pressure
      idx = 0; got0 = 0; got1 = 0; cyc = 0;
      while ((got0 < 5 || got1 < 5) && cyc < 300) begin
         out0_ready = 1'($urandom_range(0, 1));
         out1_ready = 1'($urandom_range(0, 1));
         if (idx < 10) begin
            in_valid = 1'b1;
            in_sel   = 1'(idx % 2);
            in_data  = 16'(idx);
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (out0_valid && out0_ready) begin
            chk("stream_out0", {16'd0, out0_data}, 32'(2 * got0));
            got0++;
         end
         if (out1_valid && out1_ready) begin
            chk("stream_out1", {16'd0, out1_data}, 32'(2 * got1 + 1));
            got1++;
         end
         if (in_valid && in_ready) idx++;
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      chk("stream_got0", 32'(got0), 32'd5);
      chk("stream_got1", 32'(got1), 32'd5);
      chk("stream_out0_empty", {31'd0, out0_valid}, 32'd0);
      chk("stream_out1_empty", {31'd0, out1_valid}, 32'd0);

      // Asynchronous reset while both FIFOs hold data
      out0_ready = 1'b0; out1_ready = 1'b0;
      in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h0011;
      tick();
      in_sel = 1'b1; in_data = 16'h0022;
      tick();
      in_valid = 1'b0;
      chk("t5_pre_out0_valid", {31'd0, out0_valid}, 32'd1);
      chk("t5_pre_out1_valid", {31'd0, out1_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_async_out0_valid", {31'd0, out0_valid}, 32'd0);
      chk("t5_async_out1_valid", {31'd0, out1_valid}, 32'd0);
      chk("t5_async_out0_data", {16'd0, out0_data}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      in_sel = 1'b0;
      #1;
      chk("t5_in_ready_sel0", {31'd0, in_ready}, 32'd1);
      in_sel = 1'b1;
      #1;
      chk("t5_in_ready_sel1", {31'd0, in_ready}, 32'd1);
      chk("t5_out1_empty", {31'd0, out1_valid}, 32'd0);

      // 17 pops from output 0 (wraps a 4-bit counter to 1)
      out0_ready = 1'b1; out1_ready = 1'b1;
      in_sel = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 17; i++) begin
         in_data = 16'(16'h0100 + i);
         tick();
      end
      in_valid = 1'b0;
      tick();
      chk("t6_out0_empty", {31'd0, out0_valid}, 32'd0);
      chk("t6_out0_last", {16'd0, out0_data}, 32'h0110);
`ifdef DEMUX_COUNT_EN
      chk("t6_count0_wrap", {28'd0, out0_count}, 32'd1);
`else
      chk("t6_count0_tied", {28'd0, out0_count}, 32'd0);
`endif
      chk("t6_count1", {28'd0, out1_count}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
